// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit for the 16-bit TSC CPU. It sequences fetch, decode, execute, memory and
// write-back, handles the memory ready handshake with a wait timeout, counts retired instructions and holds a sticky halt.
module mc_control_fsm #(
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           opcode,
  input  logic [5:0]           func,
  input  logic                 bcond,
  input  logic                 mem_ready,
  output logic                 read_m,
  output logic                 write_m,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_inc_write,
  output logic                 tgt_write,
  output logic                 mdr_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic                 mem_to_reg,
  output logic                 pc_to_reg,
  output logic                 alu_src_b,
  output logic [1:0]           alu_mode,
  output logic                 wwd_en,
  output logic [CNT_WIDTH-1:0] num_inst,
  output logic                 is_halted,
  output logic                 mem_error,
  output logic [2:0]           state
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  // The timeout fires on the MEM_TIMEOUT-th consecutive wait cycle, i.e. when the
  // count of earlier wait cycles equals MEM_TIMEOUT-1.
  localparam bit TMO_EN   = (MEM_TIMEOUT != 0);
  localparam int TMO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  logic is_rtype, is_branch, is_itype, is_lwd, is_swd, is_jmp, is_jal;
  logic is_ralu, is_jpr, is_jrl, is_wwd, is_hlt;

  assign is_rtype  = (opcode == 4'd15);
  assign is_branch = (opcode <= 4'd3);
  assign is_itype  = (opcode >= 4'd4) && (opcode <= 4'd6);
  assign is_lwd    = (opcode == 4'd7);
  assign is_swd    = (opcode == 4'd8);
  assign is_jmp    = (opcode == 4'd9);
  assign is_jal    = (opcode == 4'd10);
  assign is_ralu   = is_rtype && (func <= 6'd7);
  assign is_jpr    = is_rtype && (func == 6'd25);
  assign is_jrl    = is_rtype && (func == 6'd26);
  assign is_wwd    = is_rtype && (func == 6'd28);
  assign is_hlt    = is_rtype && (func == 6'd29);

  logic [2:0]           next_state;
  logic                 retire;
  logic                 waiting;
  logic                 tmo_hit;
  logic [TMO_WIDTH-1:0] wait_cnt;

  assign waiting   = ((state == S_IF) || (state == S_MEM)) && !mem_ready;
  assign tmo_hit   = TMO_EN && waiting && (wait_cnt == TMO_WIDTH'(TMO_LAST));
  assign is_halted = (state == S_HALT);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    read_m       = 1'b0;
    write_m      = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_inc_write = 1'b0;
    tgt_write    = 1'b0;
    mdr_write    = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    reg_write    = 1'b0;
    reg_dst      = 2'd0;
    mem_to_reg   = 1'b0;
    pc_to_reg    = 1'b0;
    alu_src_b    = 1'b0;
    alu_mode     = 2'd0;
    wwd_en       = 1'b0;
    retire       = 1'b0;
    next_state   = state;

    // NOTE: reset_n gates the strobes combinationally so memory requests drop the instant reset asserts.
    if (reset_n) begin
      case (state)
        S_IF: begin
          read_m = 1'b1;
          if (mem_ready) begin
            ir_write     = 1'b1;
            pc_inc_write = 1'b1;
            next_state   = S_ID;
          end else if (tmo_hit) begin
            next_state = S_HALT;
          end
        end

        S_ID: begin
          if (is_jmp || is_jal) begin
            pc_write   = 1'b1;
            pc_src     = 2'd2;
            reg_write  = is_jal;
            reg_dst    = is_jal ? 2'd2 : 2'd0;
            pc_to_reg  = is_jal;
            retire     = 1'b1;
            next_state = S_IF;
          end else if (is_jpr || is_jrl) begin
            pc_write   = 1'b1;
            pc_src     = 2'd3;
            reg_write  = is_jrl;
            reg_dst    = is_jrl ? 2'd2 : 2'd0;
            pc_to_reg  = is_jrl;
            retire     = 1'b1;
            next_state = S_IF;
          end else if (is_hlt) begin
            retire     = 1'b1;
            next_state = S_HALT;
          end else if (is_branch || is_itype || is_lwd || is_swd || is_ralu) begin
            tgt_write  = 1'b1;
            next_state = S_EX;
          end else begin
            // WWD and every undefined encoding just advance the PC.
            wwd_en     = is_wwd;
            pc_write   = 1'b1;
            retire     = 1'b1;
            next_state = S_IF;
          end
        end

        S_EX: begin
          if (is_branch) begin
            alu_mode   = 2'd2;
            pc_write   = 1'b1;
            pc_src     = bcond ? 2'd1 : 2'd0;
            retire     = 1'b1;
            next_state = S_IF;
          end else if (is_ralu) begin
            alu_mode   = 2'd1;
            next_state = S_WB;
          end else if (is_itype) begin
            alu_mode   = 2'd3;
            alu_src_b  = 1'b1;
            next_state = S_WB;
          end else if (is_lwd || is_swd) begin
            alu_src_b  = 1'b1;
            next_state = S_MEM;
          end else begin
            next_state = S_IF;
          end
        end

        S_MEM: begin
          iord    = 1'b1;
          read_m  = is_lwd;
          write_m = is_swd;
          if (mem_ready) begin
            if (is_lwd) begin
              mdr_write  = 1'b1;
              next_state = S_WB;
            end else begin
              pc_write   = 1'b1;
              retire     = 1'b1;
              next_state = S_IF;
            end
          end else if (tmo_hit) begin
            next_state = S_HALT;
          end
        end

        S_WB: begin
          reg_write  = 1'b1;
          pc_write   = 1'b1;
          reg_dst    = is_ralu ? 2'd0 : 2'd1;
          mem_to_reg = is_lwd;
          retire     = 1'b1;
          next_state = S_IF;
        end

        S_HALT:  next_state = S_HALT;
        default: next_state = S_IF;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IF;
      num_inst  <= '0;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      state <= next_state;
      if (retire) num_inst <= num_inst + CNT_WIDTH'(1);
      if (next_state != state) wait_cnt <= '0;
      else if (waiting)        wait_cnt <= wait_cnt + TMO_WIDTH'(1);
      if (tmo_hit) mem_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: an instruction-level trace model expands each directed
// instruction into its expected per-cycle outputs, and one process drives and compares every cycle.
module tb_mc_control_fsm;

  localparam int CNT_W = 4;
  localparam int TMO   = 4;
  localparam int TMO_W = 3;

  localparam logic [2:0] IF_S = 3'd0, ID_S = 3'd1, EX_S = 3'd2, MEM_S = 3'd3, WB_S = 3'd4, HALT_S = 3'd5;

  typedef struct packed {
    logic       read_m, write_m, iord, ir_write, pc_inc_write, tgt_write, mdr_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg, pc_to_reg, alu_src_b;
    logic [1:0] alu_mode;
    logic       wwd_en;
  } ctl_t;

  typedef struct {
    logic [3:0] op;
    logic [5:0] fn;
    logic       bc, rdy, rst;
    logic [2:0] st;
    ctl_t       ctl;
    int         num;
    logic       halt, err;
  } cyc_t;

  typedef enum {C_BR, C_ITYPE, C_LWD, C_SWD, C_JMP, C_JAL, C_RALU, C_JPR, C_JRL, C_WWD, C_HLT, C_NOP} cls_t;

  logic clk, reset_n, bcond, mem_ready;
  logic [3:0] opcode;
  logic [5:0] func;
  logic read_m, write_m, iord, ir_write, pc_inc_write, tgt_write, mdr_write, pc_write;
  logic [1:0] pc_src, reg_dst, alu_mode;
  logic reg_write, mem_to_reg, pc_to_reg, alu_src_b, wwd_en, is_halted, mem_error;
  logic [CNT_W-1:0] num_inst;
  logic [2:0] state;
  ctl_t dut_ctl;

  mc_control_fsm #(.CNT_WIDTH(CNT_W), .MEM_TIMEOUT(TMO), .TMO_WIDTH(TMO_W)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func), .bcond(bcond),
    .mem_ready(mem_ready), .read_m(read_m), .write_m(write_m), .iord(iord),
    .ir_write(ir_write), .pc_inc_write(pc_inc_write), .tgt_write(tgt_write),
    .mdr_write(mdr_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg),
    .alu_src_b(alu_src_b), .alu_mode(alu_mode), .wwd_en(wwd_en), .num_inst(num_inst),
    .is_halted(is_halted), .mem_error(mem_error), .state(state)
  );

  assign dut_ctl = {read_m, write_m, iord, ir_write, pc_inc_write, tgt_write, mdr_write, pc_write,
                    pc_src, reg_write, reg_dst, mem_to_reg, pc_to_reg, alu_src_b, alu_mode, wwd_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cyc_t q[$];
  int   m_num;
  bit   m_halt, m_err;
  int   n_checks, n_fail;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @entry %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic cls_t classify(input logic [3:0] op, input logic [5:0] fn);
    if (op <= 4'd3) return C_BR;
    if (op <= 4'd6) return C_ITYPE;
    case (op)
      4'd7:  return C_LWD;
      4'd8:  return C_SWD;
      4'd9:  return C_JMP;
      4'd10: return C_JAL;
      4'd15: begin
        if (fn <= 6'd7) return C_RALU;
        case (fn)
          6'd25:   return C_JPR;
          6'd26:   return C_JRL;
          6'd28:   return C_WWD;
          6'd29:   return C_HLT;
          default: return C_NOP;
        endcase
      end
      default: return C_NOP;
    endcase
  endfunction

  task automatic push(input logic [3:0] op, input logic [5:0] fn, input logic bc, input logic rdy,
                      input logic rst, input logic [2:0] st, input ctl_t c);
    cyc_t e;
    e.op = op; e.fn = fn; e.bc = bc; e.rdy = rdy; e.rst = rst; e.st = st; e.ctl = c;
    e.num = m_num; e.halt = m_halt; e.err = m_err;
    q.push_back(e);
  endtask

  task automatic retire_one();
    m_num = (m_num + 1) % (1 << CNT_W);
  endtask

  task automatic add_reset();
    m_num = 0; m_halt = 0; m_err = 0;
    push(4'd0, 6'd0, 1'b0, 1'b0, 1'b1, IF_S, '0);
  endtask

  task automatic add_halt(input int n);
    for (int i = 0; i < n; i++) push(4'd15, 6'd29, 1'b0, i[0], 1'b0, HALT_S, '0);
  endtask

  task automatic add_fetch_waits(input int n);
    ctl_t c;
    c = '0; c.read_m = 1'b1;
    for (int i = 0; i < n; i++) push(4'd4, 6'd0, 1'b0, 1'b0, 1'b0, IF_S, c);
  endtask

  // Expand one instruction into its expected cycles. A wait run reaching TMO ends in halt with error.
  task automatic add_instr(input logic [3:0] op, input logic [5:0] fn, input int if_w, input int mem_w, input logic bc);
    cls_t k;
    ctl_t c;
    k = classify(op, fn);
    c = '0; c.read_m = 1'b1;
    for (int i = 0; i < if_w; i++) begin
      push(op, fn, bc, 1'b0, 1'b0, IF_S, c);
      if (i + 1 == TMO) begin m_halt = 1; m_err = 1; return; end
    end
    c.ir_write = 1'b1; c.pc_inc_write = 1'b1;
    push(op, fn, bc, 1'b1, 1'b0, IF_S, c);

    c = '0;
    case (k)
      C_JMP:   begin c.pc_write = 1; c.pc_src = 2'd2; end
      C_JAL:   begin c.pc_write = 1; c.pc_src = 2'd2; c.reg_write = 1; c.reg_dst = 2'd2; c.pc_to_reg = 1; end
      C_JPR:   begin c.pc_write = 1; c.pc_src = 2'd3; end
      C_JRL:   begin c.pc_write = 1; c.pc_src = 2'd3; c.reg_write = 1; c.reg_dst = 2'd2; c.pc_to_reg = 1; end
      C_WWD:   begin c.wwd_en = 1; c.pc_write = 1; end
      C_NOP:   c.pc_write = 1;
      C_HLT:   c = '0;
      default: c.tgt_write = 1;
    endcase
    push(op, fn, bc, 1'b1, 1'b0, ID_S, c);
    if (k inside {C_JMP, C_JAL, C_JPR, C_JRL, C_WWD, C_NOP}) begin retire_one(); return; end
    if (k == C_HLT) begin retire_one(); m_halt = 1; return; end

    c = '0;
    case (k)
      C_RALU:  c.alu_mode = 2'd1;
      C_ITYPE: begin c.alu_mode = 2'd3; c.alu_src_b = 1; end
      C_BR:    begin c.alu_mode = 2'd2; c.pc_write = 1; c.pc_src = bc ? 2'd1 : 2'd0; end
      default: c.alu_src_b = 1;
    endcase
    push(op, fn, bc, 1'b1, 1'b0, EX_S, c);
    if (k == C_BR) begin retire_one(); return; end

    if (k == C_LWD || k == C_SWD) begin
      c = '0; c.iord = 1; c.read_m = (k == C_LWD); c.write_m = (k == C_SWD);
      for (int i = 0; i < mem_w; i++) begin
        push(op, fn, bc, 1'b0, 1'b0, MEM_S, c);
        if (i + 1 == TMO) begin m_halt = 1; m_err = 1; return; end
      end
      if (k == C_LWD) c.mdr_write = 1; else c.pc_write = 1;
      push(op, fn, bc, 1'b1, 1'b0, MEM_S, c);
      if (k == C_SWD) begin retire_one(); return; end
    end

    c = '0; c.reg_write = 1; c.pc_write = 1;
    c.reg_dst = (k == C_RALU) ? 2'd0 : 2'd1;
    c.mem_to_reg = (k == C_LWD);
    push(op, fn, bc, 1'b1, 1'b0, WB_S, c);
    retire_one();
  endtask

  initial begin
    int s0;
    reset_n = 1'b0; opcode = '0; func = '0; bcond = 1'b0; mem_ready = 1'b0;
    n_checks = 0; n_fail = 0;

    add_reset();
    s0 = q.size(); add_instr(4'd4, 6'd0, 0, 0, 1'b0);                  // ADI
    check("pin_adi_len", -1, q.size() - s0, 4);
    check("pin_adi_wb_ctl", -1, 32'(q[s0 + 3].ctl), 32'h940);
    s0 = q.size(); add_instr(4'd7, 6'd0, 3, 2, 1'b0);                  // LWD with waits
    check("pin_lwd_len", -1, q.size() - s0, 10);
    s0 = q.size(); add_instr(4'd1, 6'd0, 0, 0, 1'b1);                  // BEQ taken
    check("pin_beq_len", -1, q.size() - s0, 3);
    add_instr(4'd1, 6'd0, 0, 0, 1'b0);                                 // BEQ not taken
    s0 = q.size(); add_instr(4'd10, 6'd0, 0, 0, 1'b0);                 // JAL
    check("pin_jal_len", -1, q.size() - s0, 2);
    check("pin_jal_id_ctl", -1, 32'(q[s0 + 1].ctl), 32'hD90);
    add_instr(4'd15, 6'd0, 0, 0, 1'b0);                                // R-ALU add
    add_instr(4'd8, 6'd0, 0, 1, 1'b0);                                 // SWD, 1 wait
    add_instr(4'd8, 6'd0, 3, 3, 1'b0);                                 // SWD, ready on last allowed cycle
    add_instr(4'd9, 6'd0, 0, 0, 1'b0);                                 // JMP
    add_instr(4'd15, 6'd25, 0, 0, 1'b0);                               // JPR
    add_instr(4'd15, 6'd26, 0, 0, 1'b0);                               // JRL
    add_instr(4'd15, 6'd28, 0, 0, 1'b0);                               // WWD
    add_instr(4'd12, 6'd0, 0, 0, 1'b0);                                // undefined opcode
    add_instr(4'd15, 6'd40, 0, 0, 1'b0);                               // undefined func
    add_instr(4'd5, 6'd0, 1, 0, 1'b0);                                 // ORI
    add_instr(4'd6, 6'd0, 0, 0, 1'b0);                                 // LHI
    add_instr(4'd15, 6'd29, 0, 0, 1'b0);                               // HLT, 17th retire wraps to 1
    check("pin_wrap_num", -1, m_num, 1);
    add_halt(3);
    add_reset();
    add_fetch_waits(2);
    add_reset();                                                       // reset mid-IF
    add_instr(4'd4, 6'd0, 3, 0, 1'b0);                                 // counter must restart from 0
    add_instr(4'd15, 6'd3, 0, 0, 1'b0);
    s0 = q.size(); add_instr(4'd4, 6'd0, 9, 0, 1'b0);                  // IF timeout
    check("pin_tmo_len", -1, q.size() - s0, 4);
    add_halt(3);
    add_reset();
    add_instr(4'd7, 6'd0, 0, 9, 1'b0);                                 // MEM timeout
    add_halt(2);
    add_reset();

    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      reset_n   = !q[i].rst;
      opcode    = q[i].op;
      func      = q[i].fn;
      bcond     = q[i].bc;
      mem_ready = q[i].rdy;
      #2;
      check("ctl",       i, 32'(dut_ctl),   32'(q[i].ctl));
      check("state",     i, 32'(state),     32'(q[i].st));
      check("num_inst",  i, 32'(num_inst),  32'(q[i].num));
      check("is_halted", i, 32'(is_halted), 32'(q[i].halt));
      check("mem_error", i, 32'(mem_error), 32'(q[i].err));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control unit for the 16-bit TSC CPU datapath. It replaces the single-flag fetch/PVS sequencing with an explicit state machine.
- Adds a memory ready handshake with variable latency, a wait-state timeout, per-instruction state paths, a retired-instruction counter and a sticky halt.
- Sits between the instruction register / ALU bcond and the datapath muxes and memory strobes. The datapath owns all data registers (PC, IR, pc_plus1, target, MDR).

Parameters:
- CNT_WIDTH, 16, width of num_inst.
- MEM_TIMEOUT, 255, maximum wait cycles per memory access before error halt; 0 disables the timeout.
- TMO_WIDTH, 8, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- opcode  in  4  IR[15:12].
- func  in  6  IR[5:0].
- bcond  in  1  ALU branch-condition result, valid in EX.
- mem_ready  in  1  memory completes the current access this cycle.
- read_m  out  1  memory read request.
- write_m  out  1  memory write request.
- iord  out  1  address source: 0 = PC, 1 = ALU result.
- ir_write  out  1  latch data into IR.
- pc_inc_write  out  1  latch PC+1 into pc_plus1.
- tgt_write  out  1  latch branch target (pc_plus1 + imm) into target.
- mdr_write  out  1  latch memory data into MDR.
- pc_write  out  1  update PC.
- pc_src  out  2  PC source: 0 = pc_plus1, 1 = target, 2 = jump address, 3 = rs.
- reg_write  out  1  register file write.
- reg_dst  out  2  write register: 0 = IR[7:6], 1 = IR[9:8], 2 = $2.
- mem_to_reg  out  1  write data = MDR.
- pc_to_reg  out  1  write data = pc_plus1.
- alu_src_b  out  1  ALU B: 0 = rt, 1 = sign-extended imm.
- alu_mode  out  2  ALU mode: 0 = add, 1 = R-type func, 2 = branch compare, 3 = I-type op.
- wwd_en  out  1  load output_port.
- num_inst  out  CNT_WIDTH  retired-instruction count.
- is_halted  out  1  CPU halted.
- mem_error  out  1  timeout occurred (sticky).
- state  out  3  current state (debug).

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Reset forces IF, num_inst=0, wait counter=0, is_halted=0, mem_error=0.
- While reset_n=0, every strobe output is 0, including read_m.
- All strobes are combinational from state and the inputs. Any strobe not listed for a state is 0.
- IF:
  - read_m=1, iord=0. Hold in IF while mem_ready=0.
  - On mem_ready=1: ir_write=1, pc_inc_write=1, go to ID.
- ID:
  - JMP (9): pc_write, pc_src=2.
  - JAL (10): pc_write, pc_src=2, reg_write, reg_dst=2, pc_to_reg.
  - JPR (15/25): pc_write, pc_src=3.
  - JRL (15/26): pc_write, pc_src=3, reg_write, reg_dst=2, pc_to_reg.
  - WWD (15/28): wwd_en, pc_write, pc_src=0.
  - Undefined opcode/func: pc_write, pc_src=0 (NOP).
  - Each case above retires in ID and goes to IF.
  - HLT (15/29): go to HALT.
  - All others: tgt_write=1, go to EX.
- EX:
  - R-ALU (15/0-7): alu_mode=1, alu_src_b=0, go to WB.
  - ADI/ORI/LHI (4-6): alu_mode=3, alu_src_b=1, go to WB.
  - LWD/SWD (7, 8): alu_mode=0, alu_src_b=1, go to MEM.
  - Branch (0-3): alu_mode=2, alu_src_b=0, pc_write, pc_src = bcond ? 1 : 0, retire, go to IF.
- MEM:
  - iord=1; read_m=1 for LWD, write_m=1 for SWD. Hold while mem_ready=0.
  - On ready, LWD: mdr_write, go to WB.
  - On ready, SWD: pc_write, pc_src=0, retire, go to IF.
- WB:
  - reg_write, pc_write, pc_src=0, retire, go to IF.
  - reg_dst: 0 for R-ALU, 1 for I-type and LWD.
  - mem_to_reg=1 for LWD only.
- Retire: num_inst increments by 1 on the clock edge leaving the retiring state. Entering HALT via HLT also counts. num_inst wraps modulo 2^CNT_WIDTH.
- Wait counter:
  - Counts cycles in IF/MEM with mem_ready=0; clears on any state change.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT while mem_ready=0: go to HALT, mem_error=1, no retire. Any partial IR/MDR write is suppressed.
  - mem_ready=1 on the same cycle the counter reaches MEM_TIMEOUT wins; the access completes normally.
- HALT: is_halted=1 and all strobes 0. HALT is absorbing; only reset exits.
- Reset asserted mid-access drops read_m/write_m immediately (asynchronous). Nothing retires.

Test Plan:
- ADI with mem_ready tied 1 -> states IF, ID, EX, WB (4 cycles); reg_write/reg_dst=1/pc_write in WB; num_inst 0->1.
- LWD with 3 wait cycles in IF and 2 in MEM -> read_m held 4 cycles in IF and 3 in MEM; mdr_write then WB with mem_to_reg=1; 10 cycles total.
- BEQ with bcond=1 then bcond=0 -> pc_src=1 then pc_src=0 in EX; each retires in 3 cycles; num_inst +2.
- JAL -> retires in ID after 2 cycles; pc_src=2, reg_dst=2, pc_to_reg=1 asserted together.
- MEM_TIMEOUT=4, mem_ready held 0 in IF -> HALT after 4 wait cycles; mem_error=1, is_halted=1, num_inst unchanged.
- HLT, then reset pulse mid-IF of a later run -> is_halted=1 and num_inst incremented on HLT; reset drops read_m combinationally, state=IF, counters=0.
